// File: rtl/gfx_cmd_dispatch.sv
// rtl/gfx_cmd_dispatch.sv - FWFT command FIFO front-end for the circle engine
module gfx_cmd_dispatch #(
  parameter logic [31:0] FRAME_BASE_RST = 32'h1000_0000,
  parameter logic [7:0]  OP_NOP         = 8'h00,
  parameter logic [7:0]  OP_CIRCLE      = 8'h02,
  parameter logic [7:0]  OP_SET_BASE    = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_dout,
  input  logic        cmd_empty,
  output logic        cmd_rd_en,
  input  logic        ce_ready,
  output logic [23:0] ce_color,
  output logic [31:0] ce_arguments,
  output logic        ce_color_valid,
  output logic        ce_arguments_valid,
  output logic        ce_trigger,
  output logic [31:0] frame_base,
  output logic        busy,
  output logic [15:0] circles_issued,
  output logic [7:0]  err_count
);

  localparam logic [2:0] ST_FETCH      = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_ARG        = 3'd2;
  localparam logic [2:0] ST_WAIT_RDY   = 3'd3;
  localparam logic [2:0] ST_SEND_COLOR = 3'd4;
  localparam logic [2:0] ST_SEND_ARGS  = 3'd5;

  logic [2:0]  state;
  logic [7:0]  opcode_q;
  logic [23:0] color_q;
  logic [31:0] arg_q;

  // Gated by rst so the FIFO is never popped while reset is held.
  assign cmd_rd_en          = rst && !cmd_empty && ((state == ST_FETCH) || (state == ST_ARG));
  assign ce_color_valid     = (state == ST_SEND_COLOR);
  assign ce_arguments_valid = (state == ST_SEND_ARGS);
  assign ce_trigger         = (state == ST_SEND_ARGS);
  assign busy               = (state != ST_FETCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_FETCH;
      opcode_q       <= 8'h00;
      color_q        <= 24'h000000;
      arg_q          <= 32'h0000_0000;
      ce_color       <= 24'h000000;
      ce_arguments   <= 32'h0000_0000;
      frame_base     <= FRAME_BASE_RST;
      circles_issued <= 16'h0000;
      err_count      <= 8'h00;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!cmd_empty) begin
            opcode_q <= cmd_dout[31:24];
            color_q  <= cmd_dout[23:0];
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if ((opcode_q == OP_CIRCLE) || (opcode_q == OP_SET_BASE)) begin
            state <= ST_ARG;
          end else begin
            if ((opcode_q != OP_NOP) && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'h01;
            end
            state <= ST_FETCH;
          end
        end
        ST_ARG: begin
          if (!cmd_empty) begin
            arg_q <= cmd_dout;
            state <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          // Both command kinds wait for an idle engine, so frame_base only moves while it is idle.
          if (ce_ready) begin
            if (opcode_q == OP_SET_BASE) begin
              frame_base <= arg_q;
              state      <= ST_FETCH;
            end else begin
              ce_color     <= color_q;
              ce_arguments <= arg_q;
              state        <= ST_SEND_COLOR;
            end
          end
        end
        ST_SEND_COLOR: begin
          state <= ST_SEND_ARGS;
        end
        ST_SEND_ARGS: begin
          circles_issued <= circles_issued + 16'h0001;
          state          <= ST_FETCH;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_cmd_dispatch.sv
// tb/tb_gfx_cmd_dispatch.sv - randomized self-checking bench for gfx_cmd_dispatch
module tb_gfx_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cmd_dout = 32'h0;
  logic        cmd_empty = 1'b1;
  logic        cmd_rd_en;
  logic        ce_ready = 1'b1;
  logic [23:0] ce_color;
  logic [31:0] ce_arguments;
  logic        ce_color_valid;
  logic        ce_arguments_valid;
  logic        ce_trigger;
  logic [31:0] frame_base;
  logic        busy;
  logic [15:0] circles_issued;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo[$];
  logic        gap = 1'b0;
  logic        ready_before_edge = 1'b1;
  int          exp_circles = 0;
  int          exp_err = 0;
  logic [31:0] exp_fb = 32'h1000_0000;

  gfx_cmd_dispatch dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_dout          (cmd_dout),
    .cmd_empty         (cmd_empty),
    .cmd_rd_en         (cmd_rd_en),
    .ce_ready          (ce_ready),
    .ce_color          (ce_color),
    .ce_arguments      (ce_arguments),
    .ce_color_valid    (ce_color_valid),
    .ce_arguments_valid(ce_arguments_valid),
    .ce_trigger        (ce_trigger),
    .frame_base        (frame_base),
    .busy              (busy),
    .circles_issued    (circles_issued),
    .err_count         (err_count)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    cmd_empty = (fifo.size() == 0) || gap;
    cmd_dout  = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    refresh();
  endtask

  task automatic set_gap(input logic v);
    gap = v;
    refresh();
  endtask

  // One clock: FIFO pop decided from pre-edge cmd_rd_en, outputs settled on return.
  task automatic tick();
    logic rd;
    #1;
    rd = cmd_rd_en;
    ready_before_edge = ce_ready;
    @(posedge clk);
    #1;
    if (rd) void'(fifo.pop_front());
    refresh();
    #1;
  endtask

  task automatic test_reset();
    push(32'h02FF0000);
    push(32'h0500A032);
    ce_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (frame_base !== 32'h1000_0000) begin errors++; $display("FAIL reset_frame_base got %h expected %h", frame_base, 32'h1000_0000); end
    checks++; if ({ce_color_valid, ce_arguments_valid, ce_trigger} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b expected 000", {ce_color_valid, ce_arguments_valid, ce_trigger}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (cmd_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", cmd_rd_en); end
    checks++; if ({ce_color, ce_arguments} !== 56'h0) begin errors++; $display("FAIL reset_ce_data got %h expected 0", {ce_color, ce_arguments}); end
    checks++; if ({circles_issued, err_count} !== 24'h0) begin errors++; $display("FAIL reset_counters got %h expected 0", {circles_issued, err_count}); end
  endtask

  task automatic test_latency();
    logic [3:0] exp_vec;
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      exp_vec = {(c == 0) || (c == 2), c == 4, c == 5, c == 5};
      checks++;
      if ({cmd_rd_en, ce_color_valid, ce_arguments_valid, ce_trigger} !== exp_vec) begin
        errors++;
        $display("FAIL latency_cycle%0d got %b expected %b", c, {cmd_rd_en, ce_color_valid, ce_arguments_valid, ce_trigger}, exp_vec);
      end
      if (c == 4) begin
        checks++; if (ce_color !== 24'hFF0000) begin errors++; $display("FAIL latency_color got %h expected ff0000", ce_color); end
      end
      if (c == 5) begin
        checks++; if (ce_arguments !== 32'h0500A032) begin errors++; $display("FAIL latency_args got %h expected 0500a032", ce_arguments); end
      end
      if (c == 6) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL latency_idle got %b expected 0", busy); end
      end
      tick();
    end
    exp_circles = 1;
    checks++; if (circles_issued !== 16'(exp_circles)) begin errors++; $display("FAIL latency_count got %0d expected %0d", circles_issued, exp_circles); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] cq[$];
    logic [31:0] aq[$];
    logic [23:0] col;
    logic [31:0] arg;
    int hold = 0, rise = -1, n_cv = 0, n_av = 0;
    logic prev_cv = 1'b0;
    ce_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      col = 24'($urandom);
      arg = $urandom;
      push({8'h02, col});
      push(arg);
      cq.push_back(col);
      aq.push_back(arg);
    end
    for (int c = 0; c < 300 && n_av < 2; c++) begin
      if (ce_color_valid) begin
        checks++; if (cq.size() == 0 || ce_color !== cq[0]) begin errors++; $display("FAIL b2b_color got %h expected %h", ce_color, (cq.size() != 0) ? cq[0] : 24'h0); end
        if (n_cv == 1) begin
          checks++; if (c !== rise + 1) begin errors++; $display("FAIL b2b_wait got cycle %0d expected %0d", c, rise + 1); end
        end
        n_cv++;
        hold = 40;
      end
      if (prev_cv || ce_color_valid || ce_arguments_valid || ce_trigger) begin
        checks++;
        if ({ce_color_valid && prev_cv, ce_arguments_valid, ce_trigger} !== {1'b0, prev_cv, prev_cv}) begin
          errors++;
          $display("FAIL b2b_strobe_width got %b expected %b", {ce_color_valid && prev_cv, ce_arguments_valid, ce_trigger}, {1'b0, prev_cv, prev_cv});
        end
      end
      if (ce_arguments_valid) begin
        checks++; if (aq.size() == 0 || ce_arguments !== aq[0]) begin errors++; $display("FAIL b2b_args got %h expected %h", ce_arguments, (aq.size() != 0) ? aq[0] : 32'h0); end
        if (cq.size() != 0) void'(cq.pop_front());
        if (aq.size() != 0) void'(aq.pop_front());
        exp_circles++;
        n_av++;
      end
      prev_cv = ce_color_valid;
      if (hold > 0) begin
        ce_ready = 1'b0;
        hold--;
      end else begin
        if (ce_ready == 1'b0) rise = c;
        ce_ready = 1'b1;
      end
      tick();
    end
    ce_ready = 1'b1;
    checks++; if (n_av !== 2) begin errors++; $display("FAIL b2b_timeout got %0d circles expected 2", n_av); end
    tick();
    checks++; if (circles_issued !== 16'(exp_circles)) begin errors++; $display("FAIL b2b_count got %0d expected %0d", circles_issued, exp_circles); end
  endtask

  task automatic test_set_base();
    ce_ready = 1'b0;
    push(32'h03000000);
    push(32'h2000_0000);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({frame_base, ce_color_valid, ce_arguments_valid, ce_trigger} !== {exp_fb, 3'b000}) begin
        errors++;
        $display("FAIL setbase_hold cycle %0d got %h/%b expected %h/000", c, frame_base, {ce_color_valid, ce_arguments_valid, ce_trigger}, exp_fb);
      end
    end
    ce_ready = 1'b1;
    tick();
    exp_fb = 32'h2000_0000;
    checks++; if (frame_base !== exp_fb) begin errors++; $display("FAIL setbase_update got %h expected %h", frame_base, exp_fb); end
    checks++; if ({busy, ce_color_valid, ce_arguments_valid, ce_trigger} !== 4'b0000) begin errors++; $display("FAIL setbase_idle got %b expected 0000", {busy, ce_color_valid, ce_arguments_valid, ce_trigger}); end
  endtask

  task automatic test_random();
    logic [23:0] cq[$];
    logic [31:0] aq[$];
    logic [31:0] fbq[$];
    logic [23:0] col;
    logic [31:0] arg;
    logic [31:0] fb_prev;
    logic prev_cv = 1'b0;
    logic done = 1'b0;
    int hold = 0;
    fb_prev = exp_fb;
    ce_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      col = 24'($urandom);
      arg = $urandom;
      case ($urandom_range(0, 3))
        0: begin push({8'h02, col}); push(arg); cq.push_back(col); aq.push_back(arg); end
        1: begin push({8'h03, col}); push(arg); fbq.push_back(arg); exp_fb = arg; end
        2: push({8'h00, col});
        default: begin push({8'($urandom_range(4, 255)), col}); if (exp_err < 255) exp_err++; end
      endcase
    end
    for (int c = 0; c < 4000 && !done; c++) begin
      if (ce_color_valid) begin
        checks++; if (cq.size() == 0 || ce_color !== cq[0]) begin errors++; $display("FAIL rand_color got %h expected %h", ce_color, (cq.size() != 0) ? cq[0] : 24'h0); end
      end
      if (prev_cv || ce_color_valid || ce_arguments_valid || ce_trigger) begin
        checks++;
        if ({ce_color_valid && prev_cv, ce_arguments_valid, ce_trigger} !== {1'b0, prev_cv, prev_cv}) begin
          errors++;
          $display("FAIL rand_strobe_width got %b expected %b", {ce_color_valid && prev_cv, ce_arguments_valid, ce_trigger}, {1'b0, prev_cv, prev_cv});
        end
      end
      if (ce_arguments_valid) begin
        checks++; if (aq.size() == 0 || ce_arguments !== aq[0]) begin errors++; $display("FAIL rand_args got %h expected %h", ce_arguments, (aq.size() != 0) ? aq[0] : 32'h0); end
        if (cq.size() != 0) void'(cq.pop_front());
        if (aq.size() != 0) void'(aq.pop_front());
        exp_circles++;
        hold = $urandom_range(0, 8);
      end
      if (frame_base !== fb_prev) begin
        checks++;
        if (!ready_before_edge || fbq.size() == 0 || frame_base !== fbq[0]) begin
          errors++;
          $display("FAIL rand_frame_base got %h ready=%b expected %h", frame_base, ready_before_edge, (fbq.size() != 0) ? fbq[0] : fb_prev);
        end
        fb_prev = frame_base;
        if (fbq.size() != 0) void'(fbq.pop_front());
      end
      prev_cv = ce_color_valid;
      if (fifo.size() == 0 && !busy) begin
        done = 1'b1;
      end else begin
        if (hold > 0) begin
          ce_ready = 1'b0;
          hold--;
        end else begin
          ce_ready = 1'b1;
        end
        set_gap($urandom_range(0, 3) == 0);
        tick();
      end
    end
    set_gap(1'b0);
    ce_ready = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL rand_timeout got %0d words left expected 0", fifo.size()); end
    checks++; if (cq.size() + fbq.size() != 0) begin errors++; $display("FAIL rand_missing got %0d outstanding expected 0", cq.size() + fbq.size()); end
    checks++; if (frame_base !== exp_fb) begin errors++; $display("FAIL rand_fb_final got %h expected %h", frame_base, exp_fb); end
    checks++; if (circles_issued !== 16'(exp_circles)) begin errors++; $display("FAIL rand_circles got %0d expected %0d", circles_issued, exp_circles); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL rand_err got %0d expected %0d", err_count, exp_err); end
  endtask

  task automatic test_err_saturate();
    logic strobe_seen = 1'b0;
    int c = 0;
    ce_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(32'h00123456);
      push(32'h7F000000);
    end
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    while ((fifo.size() != 0 || busy) && c < 2000) begin
      tick();
      if (ce_color_valid || ce_arguments_valid || ce_trigger) strobe_seen = 1'b1;
      c++;
    end
    checks++; if (c >= 2000) begin errors++; $display("FAIL err_timeout got %0d cycles expected under 2000", c); end
    checks++; if (strobe_seen !== 1'b0) begin errors++; $display("FAIL err_strobes got %b expected 0", strobe_seen); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL err_saturate got %0d expected %0d", err_count, exp_err); end
    checks++; if ({circles_issued, frame_base} !== {16'(exp_circles), exp_fb}) begin errors++; $display("FAIL err_side_effects got %h expected %h", {circles_issued, frame_base}, {16'(exp_circles), exp_fb}); end
  endtask

  task automatic test_reset_mid_command();
    logic strobe_seen = 1'b0;
    ce_ready = 1'b1;
    push(32'h02ABCDEF);
    for (int c = 0; c < 10 && fifo.size() != 0; c++) tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ce_color_valid || ce_arguments_valid || ce_trigger) strobe_seen = 1'b1;
    end
    checks++; if ({busy, cmd_rd_en, strobe_seen} !== 3'b100) begin errors++; $display("FAIL gap_stall got %b expected 100", {busy, cmd_rd_en, strobe_seen}); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_err = 1;
    exp_circles = 0;
    exp_fb = 32'h1000_0000;
    push(32'h0500A032);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ce_color_valid || ce_arguments_valid || ce_trigger) strobe_seen = 1'b1;
    end
    checks++; if (strobe_seen !== 1'b0) begin errors++; $display("FAIL midreset_strobes got %b expected 0", strobe_seen); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL midreset_err got %0d expected %0d", err_count, exp_err); end
    checks++; if ({circles_issued, frame_base, busy} !== {16'(exp_circles), exp_fb, 1'b0}) begin errors++; $display("FAIL midreset_state got %h expected %h", {circles_issued, frame_base, busy}, {16'(exp_circles), exp_fb, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_set_base();
    test_random();
    test_err_saturate();
    test_reset_mid_command();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
